// File: rtl/ps2_code_fifo.sv
// Scan-code FIFO between ps2_interpreter and uart_tx; paces bytes one UART frame slot apart.
// Optional macro PS2_CODE_FIFO_HEX_EN emits each byte as two ASCII hex digits plus a space.
module ps2_code_fifo #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 5208,
  parameter int SLOT_BITS    = 11
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_data,
  input  logic                     i_data_valid,
  input  logic                     i_clr_ovf,
  output logic [7:0]               o_data,
  output logic                     o_send,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int AW        = $clog2(DEPTH);
  localparam int SLOT_CLKS = SLOT_BITS * CLKS_PER_BIT;
  localparam int CW        = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [CW-1:0] SLOT_LOAD = CW'(SLOT_CLKS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

  // Handshake: i_data_valid is a single-cycle strobe with no back-pressure (drops set
  // o_overflow); o_send is a single-cycle strobe qualifying o_data, spaced one slot apart.

`ifdef PS2_CODE_FIFO_HEX_EN
  typedef enum logic [2:0] {IDLE, HI, WAIT_HI, LO, WAIT_LO, SP, WAIT_SP} state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [3:0] lo_nib, lo_nib_n;
`else
  typedef enum logic {IDLE, WAIT} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic          avail;
  logic          pop, push, drop;
  state_t        state, state_n;
  logic [CW-1:0] slot_cnt, slot_cnt_n;
  logic [7:0]    data_n;
  logic          send_n;

  // A pop at this edge frees a slot, so a push into a full FIFO is still accepted.
  assign push = i_data_valid && ((count != DEPTH_C) || pop);
  assign drop = i_data_valid && !push;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      avail      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      o_count <= count_n;
      o_empty <= (count_n == '0);
      o_full  <= (count_n == DEPTH_C);
      // Set wins over clear when a drop coincides with i_clr_ovf.
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
      // Not-empty as seen by the read FSM, one edge behind the occupancy counter.
      avail <= (count != '0);
    end
  end

  always_comb begin
    state_n    = state;
    slot_cnt_n = slot_cnt;
    data_n     = o_data;
    send_n     = 1'b0;
    pop        = 1'b0;
`ifdef PS2_CODE_FIFO_HEX_EN
    lo_nib_n   = lo_nib;
    case (state)
      IDLE: if (avail) state_n = HI;
      HI: begin
        data_n     = hex_char(mem[rd_ptr][7:4]);
        lo_nib_n   = mem[rd_ptr][3:0];
        send_n     = 1'b1;
        pop        = 1'b1;
        slot_cnt_n = SLOT_LOAD;
        state_n    = WAIT_HI;
      end
      WAIT_HI: if (slot_cnt == '0) state_n = LO; else slot_cnt_n = slot_cnt - CW'(1);
      LO: begin
        data_n     = hex_char(lo_nib);
        send_n     = 1'b1;
        slot_cnt_n = SLOT_LOAD;
        state_n    = WAIT_LO;
      end
      WAIT_LO: if (slot_cnt == '0) state_n = SP; else slot_cnt_n = slot_cnt - CW'(1);
      SP: begin
        data_n     = 8'h20;
        send_n     = 1'b1;
        slot_cnt_n = SLOT_LOAD;
        state_n    = WAIT_SP;
      end
      WAIT_SP: if (slot_cnt == '0) state_n = IDLE; else slot_cnt_n = slot_cnt - CW'(1);
      default: state_n = IDLE;
    endcase
`else
    case (state)
      IDLE: begin
        if (avail) begin
          data_n     = mem[rd_ptr];
          send_n     = 1'b1;
          pop        = 1'b1;
          slot_cnt_n = SLOT_LOAD;
          state_n    = WAIT;
        end
      end
      WAIT: if (slot_cnt == '0) state_n = IDLE; else slot_cnt_n = slot_cnt - CW'(1);
      default: state_n = IDLE;
    endcase
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
      o_data   <= 8'h00;
      o_send   <= 1'b0;
`ifdef PS2_CODE_FIFO_HEX_EN
      lo_nib   <= '0;
`endif
    end else begin
      state    <= state_n;
      slot_cnt <= slot_cnt_n;
      o_data   <= data_n;
      o_send   <= send_n;
`ifdef PS2_CODE_FIFO_HEX_EN
      lo_nib   <= lo_nib_n;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_code_fifo.sv
// Bench for ps2_code_fifo: directed steps plus random traffic against a queue-based model
// of occupancy, overflow and slot-paced emission timing.
module tb_ps2_code_fifo;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int SB    = 11;
  localparam int SLOT  = CPB * SB;
`ifdef PS2_CODE_FIFO_HEX_EN
  localparam int POP_LAG = 3;
  localparam int POP_GAP = 3 * (SLOT + 1) + 1;
`else
  localparam int POP_LAG = 2;
  localparam int POP_GAP = SLOT + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       i_clr_ovf;
  logic [7:0] o_data;
  logic       o_send;
  logic [2:0] o_count;
  logic       o_empty;
  logic       o_full;
  logic       o_overflow;

  ps2_code_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .SLOT_BITS(SB)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .i_clr_ovf(i_clr_ovf), .o_data(o_data), .o_send(o_send), .o_count(o_count),
    .o_empty(o_empty), .o_full(o_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int t; logic [7:0] b; } ev_t;

  logic [7:0] exp_q[$];
  ev_t        sched[$];
  int         sz_hist[4];
  int         tick, next_pop;
  logic       exp_ovf, exp_send;
  logic [7:0] exp_data;
  logic [7:0] obs_q[$];
  int         obs_t[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + 8'(n);
    return 8'd55 + 8'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    sched.delete();
    for (int i = 0; i < 4; i++) sz_hist[i] = 0;
    next_pop = 0;
    exp_ovf  = 1'b0;
    exp_send = 1'b0;
    exp_data = 8'h00;
  endtask

  function automatic bit will_pop_next();
    return (tick + 1 >= next_pop) && (sz_hist[POP_LAG-1] > 0);
  endfunction

  // Advance the reference by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit pop, full_before, drop;
    logic [7:0] b;
    tick++;
    pop = (tick >= next_pop) && (sz_hist[POP_LAG] > 0);
    full_before = (exp_q.size() == DEPTH);
    if (pop) begin
      b = exp_q.pop_front();
      next_pop = tick + POP_GAP;
`ifdef PS2_CODE_FIFO_HEX_EN
      sched.push_back('{tick, hex_ascii(b[7:4])});
      sched.push_back('{tick + SLOT + 1, hex_ascii(b[3:0])});
      sched.push_back('{tick + 2 * (SLOT + 1), 8'h20});
`else
      sched.push_back('{tick, b});
`endif
    end
    drop = i_data_valid && full_before && !pop;
    if (i_data_valid && !drop) exp_q.push_back(i_data);
    if (drop)           exp_ovf = 1'b1;
    else if (i_clr_ovf) exp_ovf = 1'b0;
    exp_send = 1'b0;
    if (sched.size() > 0 && sched[0].t == tick) begin
      exp_send = 1'b1;
      exp_data = sched[0].b;
      void'(sched.pop_front());
    end
    sz_hist[3] = sz_hist[2];
    sz_hist[2] = sz_hist[1];
    sz_hist[1] = exp_q.size();
  endtask

  task automatic check_all();
    chk("send", 32'(o_send), 32'(exp_send));
    chk("data", 32'(o_data), 32'(exp_data));
    chk("count", 32'(o_count), 32'(exp_q.size()));
    chk("empty", 32'(o_empty), 32'(exp_q.size() == 0));
    chk("full", 32'(o_full), 32'(exp_q.size() == DEPTH));
    chk("overflow", 32'(o_overflow), 32'(exp_ovf));
    if (o_send === 1'b1) begin
      obs_q.push_back(o_data);
      obs_t.push_back(tick);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    i_data_valid = v;
    i_data       = d;
    i_clr_ovf    = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    logic [7:0] burst[3];
    burst = '{8'hE0, 8'hF0, 8'h75};
    tick = 0;
    rst = 1'b1;
    i_data = 8'h00;
    i_data_valid = 1'b0;
    i_clr_ovf = 1'b0;
    model_reset();
    #1;
    check_all();
    apply_reset();

    // Single byte into an empty FIFO.
    obs_q.delete(); obs_t.delete();
    step(1'b1, 8'h1C, 1'b0);
    idle(POP_GAP + 10);
`ifndef PS2_CODE_FIFO_HEX_EN
    chk("single_n", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) chk("single_byte", 32'(obs_q[0]), 32'h1C);
`endif

    // Prefixed burst on consecutive cycles.
    obs_q.delete(); obs_t.delete();
    for (int i = 0; i < 3; i++) step(1'b1, burst[i], 1'b0);
    idle(POP_GAP * 4);
`ifndef PS2_CODE_FIFO_HEX_EN
    chk("burst_n", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("burst_byte", 32'(obs_q[i]), 32'(burst[i]));
      chk("burst_gap", 32'(obs_t[1] - obs_t[0]), 32'd45);
      chk("burst_gap", 32'(obs_t[2] - obs_t[1]), 32'd45);
    end
`endif

    // Overflow with the reader busy, then clear and drain.
    step(1'b1, 8'h11, 1'b0);
    idle(4);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h21 + 8'(i), 1'b0);
    chk("ovf_full", 32'(o_full), 32'd1);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    obs_q.delete(); obs_t.delete();
    idle(POP_GAP * 5);
`ifndef PS2_CODE_FIFO_HEX_EN
    chk("drain_n", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("drain_byte", 32'(obs_q[i]), 32'h21 + 32'(i));
`endif

    // Push into a full FIFO exactly at a pop edge.
    step(1'b1, 8'h30, 1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h31 + 8'(i), 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 2 * POP_GAP && !hit; i++) begin
      hit = will_pop_next();
      step(hit, 8'hA5, 1'b0);
    end
    chk("fullpop_hit", 32'(hit), 32'd1);
    chk("fullpop_count", 32'(o_count), 32'd4);
    chk("fullpop_ovf", 32'(o_overflow), 32'd0);
    idle(POP_GAP * 6);

    // Reset mid-slot with three entries queued.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
    idle(10);
    apply_reset();
    obs_q.delete(); obs_t.delete();
    idle(POP_GAP * 2);
    chk("post_reset_sends", 32'(obs_q.size()), 32'd0);

`ifdef PS2_CODE_FIFO_HEX_EN
    obs_q.delete(); obs_t.delete();
    step(1'b1, 8'hF0, 1'b0);
    idle(POP_GAP + 10);
    chk("hex_n", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      chk("hex_hi", 32'(obs_q[0]), 32'h46);
      chk("hex_lo", 32'(obs_q[1]), 32'h30);
      chk("hex_sp", 32'(obs_q[2]), 32'h20);
      chk("hex_gap", 32'(obs_t[1] - obs_t[0]), 32'd45);
      chk("hex_gap", 32'(obs_t[2] - obs_t[1]), 32'd45);
    end
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 4) == 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 30) == 0));
    idle(POP_GAP * 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
